rv_fetch_unit: RTL and testbench

//  Instruction fetch stage in front of rv_controller. Holds the PC and issues word fetches to

---
 rtl/rv_fetch_unit.sv | 157 +++++++++++++++
 tb/tb_rv_fetch_unit.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/rv_fetch_unit.sv
// rv_fetch_unit: instruction fetch stage. Holds the PC, issues single-outstanding word
// fetches over a req/ready + rvalid handshake, buffers one instruction for decode and
// applies control-path redirects, squashing any fetch that is still in flight.
module rv_fetch_unit #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  output logic [31:0] instr_pc_plus4,
  output logic        instr_valid,
  input  logic        instr_ready,
  input  logic        pc_src,
  input  logic [31:0] pc_target
);

  typedef enum logic [0:0] {
    S_FETCH = 1'b0,
    S_WAIT  = 1'b1
  } state_e;

  state_e      state_q, state_d;
  logic        kill_q, kill_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] ipc_q, ipc_d;
  logic [31:0] ipc4_q, ipc4_d;
  logic        valid_q, valid_d;
  logic        req_s;
  logic        accept_s;
  logic        load_s;

  // A redirect in the same cycle suppresses the request so the next fetch uses the new pc;
  // a full buffer that is not being drained also blocks the request.
  assign req_s    = (state_q == S_FETCH) && !rst && !pc_src && (!valid_q || instr_ready);
  assign accept_s = req_s && imem_ready;

  assign imem_req       = req_s;
  assign imem_addr      = pc_q;
  assign instr          = instr_q;
  assign instr_pc       = ipc_q;
  assign instr_pc_plus4 = ipc4_q;
  assign instr_valid    = valid_q;

  // Next-state logic: redirect has top priority, then response handling, then consume.
  always_comb begin
    state_d = state_q;
    kill_d  = kill_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    ipc_d   = ipc_q;
    ipc4_d  = ipc4_q;
    valid_d = valid_q;
    load_s  = 1'b0;
    if (pc_src) begin
      pc_d    = pc_target & ~32'd3;
      valid_d = 1'b0;
      instr_d = NOP_INSTR;
      if (state_q == S_WAIT) begin
        if (imem_rvalid) begin
          // Response lands together with the redirect: drop it, nothing left in flight.
          kill_d  = 1'b0;
          state_d = S_FETCH;
        end else begin
          // Response still outstanding: mark it stale so it is discarded on arrival.
          kill_d = 1'b1;
        end
      end else begin
        state_d = S_FETCH;
      end
    end else begin
      case (state_q)
        S_FETCH: begin
          if (accept_s) begin
            state_d = S_WAIT;
            kill_d  = 1'b0;
          end else begin
            state_d = S_FETCH;
          end
        end
        S_WAIT: begin
          if (imem_rvalid) begin
            state_d = S_FETCH;
            kill_d  = 1'b0;
            load_s  = !kill_q;
          end else begin
            state_d = S_WAIT;
          end
        end
        default: begin
          state_d = S_FETCH;
          kill_d  = 1'b0;
        end
      endcase
      if (load_s) begin
        instr_d = imem_rdata;
        ipc_d   = pc_q;
        ipc4_d  = pc_q + 32'd4;
        valid_d = 1'b1;
        pc_d    = pc_q + 32'd4;
      end else if (valid_q && instr_ready) begin
        valid_d = 1'b0;
        instr_d = NOP_INSTR;
      end else begin
        valid_d = valid_q;
      end
    end
  end

  // State and output-buffer registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_FETCH;
      kill_q  <= 1'b0;
      pc_q    <= RESET_PC;
      instr_q <= NOP_INSTR;
      ipc_q   <= 32'h0000_0000;
      ipc4_q  <= 32'h0000_0004;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      kill_q  <= kill_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
      ipc_q   <= ipc_d;
      ipc4_q  <= ipc4_d;
      valid_q <= valid_d;
    end
  end

  rv_fetch_unit_chk u_chk (
    .clk         (clk),
    .rst         (rst),
    .imem_rvalid (imem_rvalid),
    .in_wait     (state_q == S_WAIT)
  );

endmodule

// Protocol checker: a response may only arrive while a fetch is outstanding.
module rv_fetch_unit_chk (
  input logic clk,
  input logic rst,
  input logic imem_rvalid,
  input logic in_wait
);

  a_rvalid_in_wait: assert property (@(posedge clk) disable iff (rst) imem_rvalid |-> in_wait);

endmodule

// File: tb/tb_rv_fetch_unit.sv
// tb_rv_fetch_unit: directed scenarios plus randomized traffic against a transaction-level
// reference model of the fetch stage (pc, outstanding/stale fetch, one-entry buffer).
module tb_rv_fetch_unit;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // DUT 1: default reset pc
  logic        rst = 1'b1;
  logic        imem_req, imem_ready = 1'b0, imem_rvalid = 1'b0;
  logic [31:0] imem_addr, imem_rdata = 32'h0;
  logic [31:0] instr, instr_pc, instr_pc_plus4, pc_target = 32'h0;
  logic        instr_valid, instr_ready = 1'b0, pc_src = 1'b0;

  // DUT 2: reset pc at the top of the address space
  logic        rst2 = 1'b1;
  logic        req2, ready2 = 1'b0, rvalid2 = 1'b0;
  logic [31:0] addr2, rdata2 = 32'h0;
  logic [31:0] instr2, ipc2, ipc4_2;
  logic        valid2;

  rv_fetch_unit dut (
    .clk(clk), .rst(rst), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ready(imem_ready), .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .instr(instr), .instr_pc(instr_pc), .instr_pc_plus4(instr_pc_plus4),
    .instr_valid(instr_valid), .instr_ready(instr_ready),
    .pc_src(pc_src), .pc_target(pc_target)
  );

  rv_fetch_unit #(.RESET_PC(32'hFFFF_FFFC)) dut2 (
    .clk(clk), .rst(rst2), .imem_req(req2), .imem_addr(addr2),
    .imem_ready(ready2), .imem_rvalid(rvalid2), .imem_rdata(rdata2),
    .instr(instr2), .instr_pc(ipc2), .instr_pc_plus4(ipc4_2),
    .instr_valid(valid2), .instr_ready(1'b0),
    .pc_src(1'b0), .pc_target(32'h0)
  );

  int checks = 0;
  int errors = 0;

  // Reference model state
  logic [31:0] m_pc    = 32'h0;
  logic        m_busy  = 1'b0;
  logic        m_stale = 1'b0;
  logic        m_valid = 1'b0;
  logic [31:0] m_instr = NOP;
  logic [31:0] m_ipc   = 32'h0;

  // Memory responder state
  logic        mem_pend  = 1'b0;
  int          mem_cnt   = 0;
  logic [31:0] mem_data  = 32'h0;
  logic [31:0] next_data = 32'h0;
  int          mem_delay = 1;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // One clock cycle: drive inputs, compare against model, advance memory and model.
  task automatic step(input bit r, input bit ir, input bit src, input logic [31:0] tgt, input bit rdy);
    logic rv;
    logic exp_req;
    logic consumed;
    logic acc;
    @(negedge clk);
    rst = r; instr_ready = ir; pc_src = src; pc_target = tgt; imem_ready = rdy;
    rv = mem_pend && (mem_cnt == 0) && !r;
    imem_rvalid = rv;
    imem_rdata  = rv ? mem_data : $urandom;
    #1;
    exp_req = !r && !m_busy && !src && (!m_valid || ir);
    check_eq("req", imem_req, exp_req);
    check_eq("addr", imem_addr, m_pc);
    check_eq("valid", instr_valid, m_valid);
    check_eq("instr", instr, m_instr);
    check_eq("instr_pc", instr_pc, m_ipc);
    check_eq("instr_pc4", instr_pc_plus4, m_ipc + 32'd4);
    // memory: reacts to what the DUT actually does
    acc = imem_req && imem_ready;
    if (r || rv) mem_pend = 1'b0;
    else if (mem_pend) mem_cnt--;
    if (acc && !r) begin
      mem_pend = 1'b1;
      mem_cnt  = ((mem_delay == 0) ? $urandom_range(1, 3) : mem_delay) - 1;
      mem_data = next_data;
      next_data = $urandom;
    end
    // model
    if (r) begin
      m_pc = 32'h0; m_busy = 1'b0; m_stale = 1'b0;
      m_valid = 1'b0; m_instr = NOP; m_ipc = 32'h0;
    end else begin
      consumed = m_valid && ir;
      if (src) begin
        m_pc = tgt & 32'hFFFF_FFFC; m_valid = 1'b0; m_instr = NOP;
        if (m_busy) begin
          if (rv) begin m_busy = 1'b0; m_stale = 1'b0; end
          else m_stale = 1'b1;
        end
      end else if (m_busy && rv) begin
        m_busy = 1'b0;
        if (m_stale) begin
          m_stale = 1'b0;
          if (consumed) begin m_valid = 1'b0; m_instr = NOP; end
        end else begin
          m_instr = imem_rdata; m_ipc = m_pc; m_valid = 1'b1; m_pc = m_pc + 32'd4;
        end
      end else begin
        if (!m_busy && exp_req && rdy) begin m_busy = 1'b1; m_stale = 1'b0; end
        if (consumed) begin m_valid = 1'b0; m_instr = NOP; end
      end
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Reset pc 0xFFFF_FFFC: one fetch, then the pc wraps to 0
    @(negedge clk);
    rst2 = 1'b0; ready2 = 1'b1;
    #1;
    check_eq("t5_addr", addr2, 32'hFFFF_FFFC);
    check_eq("t5_req", req2, 1'b1);
    @(negedge clk);
    ready2 = 1'b0; rvalid2 = 1'b1; rdata2 = 32'h0010_0093;
    @(negedge clk);
    rvalid2 = 1'b0;
    #1;
    check_eq("t5_valid", valid2, 1'b1);
    check_eq("t5_instr", instr2, 32'h0010_0093);
    check_eq("t5_pc", ipc2, 32'hFFFF_FFFC);
    check_eq("t5_pc4", ipc4_2, 32'h0000_0000);
    check_eq("t5_next_addr", addr2, 32'h0000_0000);

    // Reset state
    step(1, 0, 0, 32'h0, 0);
    step(1, 0, 0, 32'h0, 0);
    check_eq("rst_req", imem_req, 1'b0);
    check_eq("rst_valid", instr_valid, 1'b0);
    check_eq("rst_instr", instr, NOP);
    check_eq("rst_pc", instr_pc, 32'h0);
    check_eq("rst_pc4", instr_pc_plus4, 32'h4);

    // First fetch with a zero-wait memory
    next_data = 32'h0050_0093; mem_delay = 1;
    step(0, 0, 0, 32'h0, 1);
    check_eq("t1_wait_addr", imem_addr, 32'h0);
    step(0, 0, 0, 32'h0, 0);
    check_eq("t1_valid", instr_valid, 1'b1);
    check_eq("t1_instr", instr, 32'h0050_0093);
    check_eq("t1_pc", instr_pc, 32'h0);
    check_eq("t1_pc4", instr_pc_plus4, 32'h4);
    check_eq("t1_next_addr", imem_addr, 32'h4);

    // Backpressure for 5 cycles, then release
    for (int i = 0; i < 5; i++) step(0, 0, 0, 32'h0, 1);
    check_eq("t2_instr", instr, 32'h0050_0093);
    check_eq("t2_pc", instr_pc, 32'h0);
    mem_delay = 4;
    step(0, 1, 0, 32'h0, 1);

    // Redirect while waiting; the late response is dropped
    step(0, 0, 1, 32'h0000_0103, 0);
    for (int i = 0; i < 3; i++) step(0, 0, 0, 32'h0, 0);
    check_eq("t3_valid", instr_valid, 1'b0);
    check_eq("t3_instr", instr, NOP);
    check_eq("t3_addr", imem_addr, 32'h0000_0100);

    // Redirect in the same cycle as the response; next response is taken
    mem_delay = 1;
    step(0, 0, 0, 32'h0, 1);
    step(0, 0, 1, 32'h0000_0200, 0);
    check_eq("t4_addr", imem_addr, 32'h0000_0200);
    next_data = 32'h0020_0113;
    step(0, 0, 0, 32'h0, 1);
    step(0, 0, 0, 32'h0, 0);
    check_eq("t4_valid", instr_valid, 1'b1);
    check_eq("t4_pc", instr_pc, 32'h0000_0200);
    check_eq("t4_instr", instr, 32'h0020_0113);

    // Reset while a fetch is outstanding
    mem_delay = 3;
    step(0, 1, 0, 32'h0, 1);
    step(1, 0, 0, 32'h0, 0);
    check_eq("t6_valid", instr_valid, 1'b0);
    check_eq("t6_instr", instr, NOP);
    check_eq("t6_addr", imem_addr, 32'h0);
    step(0, 0, 0, 32'h0, 1);

    // Randomized traffic
    mem_delay = 0;
    for (int i = 0; i < 3000; i++) begin
      step($urandom_range(0, 99) == 0, $urandom_range(0, 3) != 0, $urandom_range(0, 9) == 0,
           $urandom, $urandom_range(0, 9) < 7);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
